// File: rtl/vdma_burst_responder_if.sv
// ----------------------------------------------------------------------------
// vdma_burst_responder_if
// Bundles every bus-level signal of the VDMA burst responder: the request
// handshake, frame control, the first-word-fall-through FIFO read port, the
// AXI4 write channels (AW/W/B) and the status outputs. Clock and reset are
// not part of the bundle.
//
// Modports:
//   master - view taken by vdma_burst_responder (drives AXI AW/W, bready,
//            request acknowledges, FIFO pop and status)
//   slave  - view taken by the environment (requester, FIFO, AXI slave)
// ----------------------------------------------------------------------------
interface vdma_burst_responder_if #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 32,
  parameter int LSIZE = 9,
  parameter int BYTES = DSIZE / 8
);
  // Request side
  logic             burst_req;
  logic             tail_req;
  logic [LSIZE-1:0] req_len;
  logic             resp;
  logic             done;
  // Frame control
  logic             frame_start;
  logic [ASIZE-1:0] base_addr;
  // FWFT FIFO
  logic             fifo_empty;
  logic [DSIZE-1:0] fifo_data;
  logic             fifo_rd_en;
  // AXI4 write address
  logic             awvalid;
  logic             awready;
  logic [ASIZE-1:0] awaddr;
  logic [7:0]       awlen;
  logic [2:0]       awsize;
  logic [1:0]       awburst;
  // AXI4 write data
  logic             wvalid;
  logic             wready;
  logic [DSIZE-1:0] wdata;
  logic [BYTES-1:0] wstrb;
  logic             wlast;
  // AXI4 write response
  logic             bvalid;
  logic             bready;
  logic [1:0]       bresp;
  // Status
  logic             busy;
  logic             err_resp;
  logic [7:0]       err_cnt;

  modport master (
    input  burst_req, tail_req, req_len, frame_start, base_addr,
    input  fifo_empty, fifo_data, awready, wready, bvalid, bresp,
    output resp, done, fifo_rd_en,
    output awvalid, awaddr, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    output busy, err_resp, err_cnt
  );

  modport slave (
    output burst_req, tail_req, req_len, frame_start, base_addr,
    output fifo_empty, fifo_data, awready, wready, bvalid, bresp,
    input  resp, done, fifo_rd_en,
    input  awvalid, awaddr, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    input  busy, err_resp, err_cnt
  );
endinterface

// File: rtl/vdma_burst_responder.sv
// ----------------------------------------------------------------------------
// vdma_burst_responder
// Accepts burst/tail write requests, turns each into one AXI4 INCR write burst
// fed from a first-word-fall-through FIFO, and advances a frame address by the
// burst size after every completed request.
//
// Ports:
//   clock  - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - vdma_burst_responder_if.master: request handshake (burst_req,
//            tail_req, req_len, resp, done), frame control (frame_start,
//            base_addr), FIFO (fifo_empty, fifo_data, fifo_rd_en), AXI4
//            AW/W/B channels and status (busy, err_resp, err_cnt)
//
// Build option:
//   VDMA_BRESP_CHECK_EN - when defined, a non-OKAY bresp at the B handshake
//                         sets the sticky err_resp flag and bumps the
//                         saturating err_cnt. When undefined both stay 0.
// ----------------------------------------------------------------------------
module vdma_burst_responder #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 32,
  parameter int LSIZE = 9,
  parameter int BYTES = DSIZE / 8
) (
  input logic                    clock,
  input logic                    rst_n,
  vdma_burst_responder_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACK   = 3'd1,
    ADDR  = 3'd2,
    DATA  = 3'd3,
    BRESP = 3'd4,
    FSH   = 3'd5
  } state_t;

  state_t           state_r;
  state_t           state_next_s;

  logic             req_s;
  logic             len_ok_s;
  logic             wvalid_s;
  logic             w_hs_s;
  logic [ASIZE-1:0] step_s;

  logic             resp_d_s;
  logic             done_d_s;
  logic             awvalid_d_s;
  logic             bready_d_s;
  logic             busy_d_s;

  logic             resp_r;
  logic             done_r;
  logic             awvalid_r;
  logic             bready_r;
  logic             busy_r;
  logic             wlast_r;
  logic [ASIZE-1:0] addr_r;
  logic             pend_r;
  logic [8:0]       len_r;
  logic [7:0]       awlen_r;
  logic [8:0]       cnt_r;

  // Tail and burst requests differ only in arbitration priority; once taken
  // they run the identical sequence, so no kind register is kept.
  assign req_s    = bus.tail_req | bus.burst_req;
  assign len_ok_s = (bus.req_len != '0) && (32'(bus.req_len) <= 32'd256);

  // wvalid follows the FIFO directly so an underrun never presents stale data.
  assign wvalid_s = (state_r == DATA) && !bus.fifo_empty;
  assign w_hs_s   = wvalid_s && bus.wready;

  // Address advance for the finished request; rejected requests latch len 0.
  assign step_s   = ASIZE'(len_r) * ASIZE'(BYTES);

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (len_ok_s) begin
            state_next_s = ACK;
          end else begin
            state_next_s = FSH;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      ACK: begin
        state_next_s = ADDR;
      end
      ADDR: begin
        if (bus.awready) begin
          state_next_s = DATA;
        end else begin
          state_next_s = ADDR;
        end
      end
      DATA: begin
        if (w_hs_s && wlast_r) begin
          state_next_s = BRESP;
        end else begin
          state_next_s = DATA;
        end
      end
      BRESP: begin
        if (bus.bvalid) begin
          state_next_s = FSH;
        end else begin
          state_next_s = BRESP;
        end
      end
      FSH: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output decode from the next state so every control output is a flop.
  always_comb begin
    resp_d_s    = 1'b0;
    done_d_s    = 1'b0;
    awvalid_d_s = 1'b0;
    bready_d_s  = 1'b0;
    busy_d_s    = 1'b0;
    // resp fires on leaving IDLE, which also covers rejected lengths (-> FSH)
    resp_d_s    = (state_r == IDLE) && (state_next_s != IDLE);
    done_d_s    = (state_next_s == FSH);
    awvalid_d_s = (state_next_s == ADDR);
    bready_d_s  = (state_next_s == BRESP);
    busy_d_s    = (state_next_s != IDLE);
  end

  // Registered control outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      resp_r    <= 1'b0;
      done_r    <= 1'b0;
      awvalid_r <= 1'b0;
      bready_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      resp_r    <= resp_d_s;
      done_r    <= done_d_s;
      awvalid_r <= awvalid_d_s;
      bready_r  <= bready_d_s;
      busy_r    <= busy_d_s;
    end
  end

  // Latch the accepted length and the matching awlen when a request is taken.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      len_r   <= 9'd0;
      awlen_r <= 8'd0;
    end else if ((state_r == IDLE) && req_s) begin
      if (len_ok_s) begin
        len_r   <= 9'(bus.req_len);
        awlen_r <= 8'(bus.req_len - LSIZE'(1));
      end else begin
        len_r   <= 9'd0;
        awlen_r <= 8'd0;
      end
    end else begin
      len_r   <= len_r;
      awlen_r <= awlen_r;
    end
  end

  // Beat counter and registered wlast; wlast is precomputed one beat ahead.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= 9'd0;
      wlast_r <= 1'b0;
    end else if (state_next_s != DATA) begin
      cnt_r   <= cnt_r;
      wlast_r <= 1'b0;
    end else if (state_r != DATA) begin
      cnt_r   <= 9'd0;
      wlast_r <= (len_r == 9'd1);
    end else if (w_hs_s) begin
      cnt_r   <= cnt_r + 9'd1;
      wlast_r <= ((cnt_r + 9'd1) == (len_r - 9'd1));
    end else begin
      cnt_r   <= cnt_r;
      wlast_r <= wlast_r;
    end
  end

  // Frame address: load in IDLE, otherwise remember frame_start until FSH,
  // where a pending reload wins over the normal increment.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= '0;
      pend_r <= 1'b0;
    end else if (state_r == IDLE) begin
      if (bus.frame_start) begin
        addr_r <= bus.base_addr;
      end else begin
        addr_r <= addr_r;
      end
      pend_r <= 1'b0;
    end else if (state_r == FSH) begin
      if (pend_r || bus.frame_start) begin
        addr_r <= bus.base_addr;
      end else begin
        addr_r <= addr_r + step_s;
      end
      pend_r <= 1'b0;
    end else begin
      addr_r <= addr_r;
      pend_r <= pend_r | bus.frame_start;
    end
  end

`ifdef VDMA_BRESP_CHECK_EN
  logic       err_resp_r;
  logic [7:0] err_cnt_r;

  // Sticky error flag and saturating error counter on non-OKAY responses.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      err_resp_r <= 1'b0;
      err_cnt_r  <= 8'd0;
    end else if ((state_r == BRESP) && bus.bvalid && (bus.bresp != 2'b00)) begin
      err_resp_r <= 1'b1;
      if (err_cnt_r != 8'hFF) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end else begin
      err_resp_r <= err_resp_r;
      err_cnt_r  <= err_cnt_r;
    end
  end

  assign bus.err_resp = err_resp_r;
  assign bus.err_cnt  = err_cnt_r;
`else
  logic unused_bresp_s;
  assign unused_bresp_s = ^bus.bresp;
  assign bus.err_resp   = 1'b0;
  assign bus.err_cnt    = 8'd0;
`endif

  assign bus.resp       = resp_r;
  assign bus.done       = done_r;
  assign bus.busy       = busy_r;
  assign bus.awvalid    = awvalid_r;
  assign bus.awaddr     = addr_r;
  assign bus.awlen      = awlen_r;
  assign bus.awsize     = 3'($clog2(BYTES));
  assign bus.awburst    = 2'b01;
  assign bus.wvalid     = wvalid_s;
  assign bus.wdata      = bus.fifo_data;
  assign bus.wstrb      = {BYTES{1'b1}};
  assign bus.wlast      = wlast_r;
  assign bus.fifo_rd_en = w_hs_s;
  assign bus.bready     = bready_r;

endmodule
